seq_piso_sdffe: RTL and testbench

SEQ_PISO_SDFFE -- requirements
Module: seq_piso_sdffe

---
 rtl/seq_piso_sdffe_if.sv | 25 ++
 rtl/seq_piso_sdffe.sv | 64 ++++++
 tb/tb_seq_piso_sdffe.sv | 115 +++++++++++
 3 files changed

// File: rtl/seq_piso_sdffe_if.sv
// Frame-in / word-out handshake bundle for the parallel-in serial-out shifter.
// master drives the frame offer and downstream ready; slave is the shifter itself.
interface seq_piso_sdffe_if #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
);
   logic [WIDTH*DEPTH-1:0] in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;
   logic                   busy;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, busy
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/seq_piso_sdffe.sv
// PISO: loads a DEPTH-word frame and emits word 0 first, one word per handshake; first word one cycle after accept.
// Output holds under out_ready=0; a new frame loads on the last-word handshake so frames stream without a bubble.
module seq_piso_sdffe #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   seq_piso_sdffe_if.slave bus
);
   localparam int CW = $clog2(DEPTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                       state_q, state_d;
   logic [DEPTH-1:0][WIDTH-1:0]  sreg_q, sreg_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic                         last;
   logic                         in_ready;
   logic                         accept;

   assign last     = (state_q == SHIFT) && (cnt_q == CW'(DEPTH - 1));
   // in_ready is gated by reset so an offer coinciding with reset is never taken
   assign in_ready = !reset && ((state_q == IDLE) || (last && bus.out_ready));
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = SHIFT;
         sreg_d  = bus.in_data;
         cnt_d   = '0;
      end else if ((state_q == SHIFT) && bus.out_ready) begin
         if (last) begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
         end else begin
            sreg_d  = {{WIDTH{1'b0}}, sreg_q[DEPTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_data  = sreg_q[0];
   assign bus.out_valid = (state_q == SHIFT);
   assign bus.busy      = (state_q == SHIFT);
   assign bus.out_last  = last;
endmodule

// File: tb/tb_seq_piso_sdffe.sv
// Directed bench for seq_piso_sdffe at WIDTH=2, DEPTH=4 with hand-computed expected words.
module tb_seq_piso_sdffe;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   seq_piso_sdffe_if #(.WIDTH(2), .DEPTH(4)) bus ();

   seq_piso_sdffe #(.WIDTH(2), .DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs for one cycle, check outputs mid-cycle, then advance past the edge.
   task automatic cyc(input string tag, input logic rst, input logic iv, input logic [7:0] id,
                      input logic ordy, input logic e_ir, input logic e_ov,
                      input logic [1:0] e_od, input logic e_ol);
      reset         = rst;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      #1;
      check({tag, ".in_ready"},  {7'd0, bus.in_ready},  {7'd0, e_ir});
      check({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, e_ov});
      check({tag, ".busy"},      {7'd0, bus.busy},      {7'd0, e_ov});
      check({tag, ".out_data"},  {6'd0, bus.out_data},  {6'd0, e_od});
      check({tag, ".out_last"},  {7'd0, bus.out_last},  {7'd0, e_ol});
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'hFF;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;

      // reset with simultaneous offer: nothing loads
      cyc("rst0", 1, 1, 8'hFF, 1, 0, 0, 0, 0);
      cyc("rst1", 1, 1, 8'hE4, 1, 0, 0, 0, 0);
      cyc("idle", 0, 0, 8'h00, 1, 1, 0, 0, 0);

      // single frame
      cyc("t1.acc", 0, 1, 8'hE4, 1, 1, 0, 0, 0);
      cyc("t1.w0",  0, 0, 8'h00, 1, 0, 1, 0, 0);
      cyc("t1.w1",  0, 0, 8'h00, 1, 0, 1, 1, 0);
      cyc("t1.w2",  0, 0, 8'h00, 1, 0, 1, 2, 0);
      cyc("t1.w3",  0, 0, 8'h00, 1, 1, 1, 3, 1);
      cyc("t1.end", 0, 0, 8'h00, 1, 1, 0, 0, 0);

      // back-pressure on word 1
      cyc("t2.acc", 0, 1, 8'hE4, 1, 1, 0, 0, 0);
      cyc("t2.w0",  0, 0, 8'h00, 1, 0, 1, 0, 0);
      cyc("t2.bp0", 0, 0, 8'h00, 0, 0, 1, 1, 0);
      cyc("t2.bp1", 0, 0, 8'h00, 0, 0, 1, 1, 0);
      cyc("t2.bp2", 0, 0, 8'h00, 0, 0, 1, 1, 0);
      cyc("t2.w1",  0, 0, 8'h00, 1, 0, 1, 1, 0);
      cyc("t2.w2",  0, 0, 8'h00, 1, 0, 1, 2, 0);
      cyc("t2.w3bp",0, 0, 8'h00, 0, 0, 1, 3, 1);
      cyc("t2.w3",  0, 0, 8'h00, 1, 1, 1, 3, 1);
      cyc("t2.end", 0, 0, 8'h00, 1, 1, 0, 0, 0);

      // back-to-back frames, no bubble
      cyc("t3.acc", 0, 1, 8'hE4, 1, 1, 0, 0, 0);
      cyc("t3.a0",  0, 1, 8'h1B, 1, 0, 1, 0, 0);
      cyc("t3.a1",  0, 1, 8'h1B, 1, 0, 1, 1, 0);
      cyc("t3.a2",  0, 1, 8'h1B, 1, 0, 1, 2, 0);
      cyc("t3.a3",  0, 1, 8'h1B, 1, 1, 1, 3, 1);
      cyc("t3.b0",  0, 1, 8'h1B, 1, 0, 1, 3, 0);
      cyc("t3.b1",  0, 1, 8'h1B, 1, 0, 1, 2, 0);
      cyc("t3.b2",  0, 1, 8'h1B, 1, 0, 1, 1, 0);
      cyc("t3.b3",  0, 0, 8'h1B, 1, 1, 1, 0, 1);
      cyc("t3.end", 0, 0, 8'h00, 1, 1, 0, 0, 0);

      // offers while busy are ignored
      cyc("t4.acc", 0, 1, 8'hE4, 1, 1, 0, 0, 0);
      cyc("t4.w0",  0, 1, 8'hFF, 1, 0, 1, 0, 0);
      cyc("t4.w1",  0, 1, 8'hFF, 1, 0, 1, 1, 0);
      cyc("t4.w2",  0, 1, 8'hFF, 1, 0, 1, 2, 0);
      cyc("t4.w3",  0, 0, 8'hFF, 1, 1, 1, 3, 1);
      cyc("t4.end", 0, 0, 8'h00, 1, 1, 0, 0, 0);

      // reset mid-frame discards the rest
      cyc("t5.acc", 0, 1, 8'hE4, 1, 1, 0, 0, 0);
      cyc("t5.w0",  0, 0, 8'h00, 1, 0, 1, 0, 0);
      cyc("t5.w1",  0, 0, 8'h00, 1, 0, 1, 1, 0);
      cyc("t5.rst", 1, 1, 8'h1B, 1, 0, 1, 2, 0);
      cyc("t5.acc2",0, 1, 8'h1B, 1, 1, 0, 0, 0);
      cyc("t5.b0",  0, 0, 8'h00, 1, 0, 1, 3, 0);
      cyc("t5.b1",  0, 0, 8'h00, 1, 0, 1, 2, 0);
      cyc("t5.b2",  0, 0, 8'h00, 1, 0, 1, 1, 0);
      cyc("t5.b3",  0, 0, 8'h00, 1, 1, 1, 0, 1);
      cyc("t5.end", 0, 0, 8'h00, 1, 1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
